// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
// uart_rx_ctrl: frame-level control FSM for an oversampling UART receiver.
// Tracks the oversample index (EDGE_CNT) and bit index (BIT_CNT), strobes the
// start/data/parity/stop checkers and the deserialiser at mid-bit, and reports
// each completed frame as DATA_VALID or FRAME_ERR.
// Ports:
//   CLK, RST (async, active-low)
//   RX_IN        serial line (idle high, already synchronised)
//   PAR_EN       frame carries a parity bit
//   PRESCALE     oversampling ratio (8, 16 or 32), captured per frame
//   STRT_GLITCH, PAR_ERR, STP_ERR   checker results
//   SAMPLE_EN, EDGE_CNT, BIT_CNT    sampler controls
//   STRT_CHK_EN, DESER_EN, PAR_CHK_EN, STP_CHK_EN   mid-bit strobes
//   DATA_VALID, FRAME_ERR           frame result pulses
//   BUSY                            high outside IDLE
module uart_rx_ctrl #(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  STRT_GLITCH,
  input  logic                  PAR_ERR,
  input  logic                  STP_ERR,
  output logic                  SAMPLE_EN,
  output logic [PRESCALE_W-1:0] EDGE_CNT,
  output logic [3:0]            BIT_CNT,
  output logic                  STRT_CHK_EN,
  output logic                  DESER_EN,
  output logic                  PAR_CHK_EN,
  output logic                  STP_CHK_EN,
  output logic                  DATA_VALID,
  output logic                  FRAME_ERR,
  output logic                  BUSY
);

  localparam int unsigned BIT_W = 4;
  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(8);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_ERR_CHK = 3'd5
  } state_t;

  state_t                r_state;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  r_par_flag;
  logic                  r_sample_en;
  logic                  r_strt_chk_en;
  logic                  r_deser_en;
  logic                  r_par_chk_en;
  logic                  r_stp_chk_en;
  logic                  r_data_valid;
  logic                  r_frame_err;
  logic                  r_busy;

  state_t                w_state_nx;
  logic [PRESCALE_W-1:0] w_prescale_nx;
  logic [PRESCALE_W-1:0] w_edge_nx;
  logic [BIT_W-1:0]      w_bit_nx;
  logic                  w_par_flag_nx;
  logic                  w_data_valid_nx;
  logic                  w_frame_err_nx;
  logic                  w_last;
  logic [PRESCALE_W-1:0] w_mid;
  logic                  w_in_frame_nx;

  // Last oversample of the current bit period.
  assign w_last = (r_edge_cnt == (r_prescale - PRESCALE_W'(1)));

  // Next-state and next-counter values; outputs are registered from these so
  // every output lines up with the cycle whose state it describes.
  always_comb begin
    w_state_nx      = r_state;
    w_prescale_nx   = r_prescale;
    w_par_flag_nx   = r_par_flag;
    w_data_valid_nx = 1'b0;
    w_frame_err_nx  = 1'b0;
    w_edge_nx       = w_last ? '0 : (r_edge_cnt + PRESCALE_W'(1));
    w_bit_nx        = w_last ? (r_bit_cnt + BIT_W'(1)) : r_bit_cnt;

    case (r_state)
      ST_IDLE: begin
        w_edge_nx = '0;
        w_bit_nx  = '0;
        if (!RX_IN) begin
          w_state_nx    = ST_START;
          w_prescale_nx = PRESCALE;
          w_par_flag_nx = 1'b0;
        end
      end
      ST_START: begin
        if (w_last) begin
          if (STRT_GLITCH) begin
            w_state_nx = ST_IDLE;
            w_edge_nx  = '0;
            w_bit_nx   = '0;
          end else begin
            w_state_nx = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_last && (r_bit_cnt == LAST_DATA_BIT)) begin
          w_state_nx = PAR_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_last) begin
          w_par_flag_nx = PAR_ERR;
          w_state_nx    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_last) begin
          w_state_nx      = ST_ERR_CHK;
          w_edge_nx       = '0;
          w_bit_nx        = '0;
          w_data_valid_nx = !r_par_flag && !STP_ERR;
          w_frame_err_nx  = r_par_flag || STP_ERR;
        end
      end
      ST_ERR_CHK: begin
        w_bit_nx = '0;
        if (!RX_IN) begin
          // Back-to-back frame: this cycle already counts as sample 0.
          w_state_nx    = ST_START;
          w_edge_nx     = PRESCALE_W'(1);
          w_prescale_nx = PRESCALE;
          w_par_flag_nx = 1'b0;
        end else begin
          w_state_nx = ST_IDLE;
          w_edge_nx  = '0;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_edge_nx  = '0;
        w_bit_nx   = '0;
      end
    endcase
  end

  // Mid-bit strobe point: just after the three centre samples.
  assign w_mid = (w_prescale_nx >> 1) + PRESCALE_W'(2);

  assign w_in_frame_nx = (w_state_nx == ST_START) || (w_state_nx == ST_DATA) ||
                         (w_state_nx == ST_PARITY) || (w_state_nx == ST_STOP);

  // State, frame registers and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state       <= ST_IDLE;
      r_prescale    <= '0;
      r_edge_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_par_flag    <= 1'b0;
      r_sample_en   <= 1'b0;
      r_strt_chk_en <= 1'b0;
      r_deser_en    <= 1'b0;
      r_par_chk_en  <= 1'b0;
      r_stp_chk_en  <= 1'b0;
      r_data_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_prescale    <= w_prescale_nx;
      r_edge_cnt    <= w_edge_nx;
      r_bit_cnt     <= w_bit_nx;
      r_par_flag    <= w_par_flag_nx;
      r_sample_en   <= w_in_frame_nx;
      r_strt_chk_en <= (w_state_nx == ST_START)  && (w_edge_nx == w_mid);
      r_deser_en    <= (w_state_nx == ST_DATA)   && (w_edge_nx == w_mid);
      r_par_chk_en  <= (w_state_nx == ST_PARITY) && (w_edge_nx == w_mid);
      r_stp_chk_en  <= (w_state_nx == ST_STOP)   && (w_edge_nx == w_mid);
      r_data_valid  <= w_data_valid_nx;
      r_frame_err   <= w_frame_err_nx;
      r_busy        <= (w_state_nx != ST_IDLE);
    end
  end

  assign SAMPLE_EN   = r_sample_en;
  assign EDGE_CNT    = r_edge_cnt;
  assign BIT_CNT     = r_bit_cnt;
  assign STRT_CHK_EN = r_strt_chk_en;
  assign DESER_EN    = r_deser_en;
  assign PAR_CHK_EN  = r_par_chk_en;
  assign STP_CHK_EN  = r_stp_chk_en;
  assign DATA_VALID  = r_data_valid;
  assign FRAME_ERR   = r_frame_err;
  assign BUSY        = r_busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl.
// A frame-position reference model (cycles since start-of-frame, divided into
// bit index and oversample index) predicts every output each cycle; a table of
// directed frame scenarios checks pulse counts, strobe positions and latencies;
// a hand-written sequence covers reset mid-frame; a random phase follows.
module tb_uart_rx_ctrl;

  localparam int unsigned PW = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          PAR_EN;
  logic [PW-1:0] PRESCALE;
  logic          STRT_GLITCH;
  logic          PAR_ERR;
  logic          STP_ERR;
  logic          SAMPLE_EN;
  logic [PW-1:0] EDGE_CNT;
  logic [3:0]    BIT_CNT;
  logic          STRT_CHK_EN;
  logic          DESER_EN;
  logic          PAR_CHK_EN;
  logic          STP_CHK_EN;
  logic          DATA_VALID;
  logic          FRAME_ERR;
  logic          BUSY;

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(.PRESCALE_W(PW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PRESCALE(PRESCALE),
    .STRT_GLITCH(STRT_GLITCH), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
    .SAMPLE_EN(SAMPLE_EN), .EDGE_CNT(EDGE_CNT), .BIT_CNT(BIT_CNT),
    .STRT_CHK_EN(STRT_CHK_EN), .DESER_EN(DESER_EN), .PAR_CHK_EN(PAR_CHK_EN),
    .STP_CHK_EN(STP_CHK_EN), .DATA_VALID(DATA_VALID), .FRAME_ERR(FRAME_ERR),
    .BUSY(BUSY)
  );

  typedef struct {
    int p;
    bit par_en;
    bit glitch;
    bit par_err;
    bit stp_err;
    bit b2b;
    int exp_dv;
    int exp_fe;
    int exp_deser;
    int exp_par_chk;
    int exp_edge;
    int exp_first;
    int exp_gap;
    int exp_busy_low;
  } scen_t;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: mode 0 idle, 1 in frame at position m_t, 2 result cycle.
  int m_mode = 0;
  int m_t    = 0;
  int m_p    = 8;
  bit m_par_sel = 1'b0;
  bit m_flag    = 1'b0;
  bit m_dv      = 1'b0;

  // Scenario observations.
  bit observing = 1'b0;
  int cur_n, cur_exp_edge;
  int o_dv, o_fe, o_deser, o_par, o_edge_bad, o_first, o_busy_low;
  int o_dv_n[2];

  function automatic logic [17:0] dut_vec();
    return {SAMPLE_EN, EDGE_CNT, BIT_CNT, STRT_CHK_EN, DESER_EN, PAR_CHK_EN,
            STP_CHK_EN, DATA_VALID, FRAME_ERR, BUSY};
  endfunction

  function automatic logic [17:0] exp_vec(output logic [17:0] mask);
    logic [17:0] v;
    int bitn, e, mid;
    v    = '0;
    mask = '1;
    if (m_mode == 1) begin
      bitn = m_t / m_p;
      e    = m_t % m_p;
      mid  = m_p / 2 + 2;
      v[17]    = 1'b1;
      v[16:11] = 6'(e);
      v[10:7]  = 4'(bitn);
      v[6]     = (bitn == 0) && (e == mid);
      v[5]     = (bitn >= 1) && (bitn <= 8) && (e == mid);
      v[4]     = m_par_sel && (bitn == 9) && (e == mid);
      v[3]     = ((bitn == 10) || ((bitn == 9) && !m_par_sel)) && (e == mid);
      v[0]     = 1'b1;
    end else if (m_mode == 2) begin
      v[2]       = m_dv;
      v[1]       = !m_dv;
      v[0]       = 1'b1;
      mask[10:7] = '0;
    end
    return v;
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [17:0] exp, mask, act;
    exp = exp_vec(mask);
    act = dut_vec();
    vectors++;
    if ((act & mask) !== (exp & mask)) begin
      miscompares++;
      $display("FAIL model_cycle: got %h, expected %h mask %h (t=%0t)", act, exp, mask, $time);
    end
  endtask

  task automatic model_advance();
    if (!RST) begin
      m_mode = 0;
      return;
    end
    case (m_mode)
      0: if (!RX_IN) begin
        m_mode = 1; m_t = 0; m_p = int'(PRESCALE); m_flag = 1'b0;
      end
      1: begin
        if ((m_t == m_p - 1) && STRT_GLITCH) begin
          m_mode = 0;
        end else begin
          if (m_t == 9 * m_p - 1) m_par_sel = PAR_EN;
          if (m_par_sel && (m_t == 10 * m_p - 1)) m_flag = PAR_ERR;
          if (m_t == (m_par_sel ? 11 : 10) * m_p - 1) begin
            m_mode = 2;
            m_dv   = !m_flag && !STP_ERR;
          end else begin
            m_t++;
          end
        end
      end
      default: if (!RX_IN) begin
        m_mode = 1; m_t = 1; m_p = int'(PRESCALE); m_flag = 1'b0;
      end else begin
        m_mode = 0;
      end
    endcase
  endtask

  task automatic observe();
    if (DATA_VALID) begin
      if (o_dv < 2) o_dv_n[o_dv] = cur_n;
      o_dv++;
      if (o_first < 0) o_first = cur_n;
    end
    if (FRAME_ERR) begin
      o_fe++;
      if (o_first < 0) o_first = cur_n;
    end
    if (DESER_EN) begin
      o_deser++;
      if (int'(EDGE_CNT) != cur_exp_edge) o_edge_bad++;
    end
    if (PAR_CHK_EN) begin
      o_par++;
      if (int'(EDGE_CNT) != cur_exp_edge) o_edge_bad++;
    end
    if (!BUSY && (o_busy_low < 0)) o_busy_low = cur_n;
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge CLK);
    check_model();
    if (observing) observe();
    @(posedge CLK);
    model_advance();
    #1;
  endtask

  function automatic logic frame_rx(input int fn, input int p);
    logic [7:0] data;
    int bp;
    data = 8'hA5;
    bp   = fn / p;
    if (bp == 0) return 1'b0;
    if (bp <= 8) return data[bp-1];
    return 1'b1;
  endfunction

  task automatic run_scen(input scen_t s, input int idx);
    int len, win, fn;
    string tag;
    PRESCALE = PW'(s.p); PAR_EN = s.par_en; STRT_GLITCH = s.glitch;
    PAR_ERR = s.par_err; STP_ERR = s.stp_err; RX_IN = 1'b1;
    repeat (3) cycle();
    RX_IN = 1'b0;
    cycle();
    o_dv = 0; o_fe = 0; o_deser = 0; o_par = 0; o_edge_bad = 0;
    o_first = -1; o_busy_low = -1; o_dv_n[0] = 0; o_dv_n[1] = 0;
    cur_exp_edge = s.exp_edge;
    observing = 1'b1;
    len = (s.par_en ? 11 : 10) * s.p;
    win = (s.b2b ? 2 : 1) * len + 4;
    for (int n = 0; n < win; n++) begin
      fn = (s.b2b && n >= len) ? n - len : n;
      if (s.glitch) RX_IN = (n == 0) ? 1'b0 : 1'b1;
      else RX_IN = frame_rx(fn, s.p);
      cur_n = n;
      cycle();
    end
    observing = 1'b0;
    tag = $sformatf("scen%0d", idx);
    check_int({tag, "_dv_count"}, o_dv, s.exp_dv);
    check_int({tag, "_fe_count"}, o_fe, s.exp_fe);
    check_int({tag, "_deser_count"}, o_deser, s.exp_deser);
    check_int({tag, "_parchk_count"}, o_par, s.exp_par_chk);
    check_int({tag, "_strobe_edge_bad"}, o_edge_bad, 0);
    check_int({tag, "_result_latency"}, o_first, s.exp_first);
    check_int({tag, "_dv_gap"}, (o_dv >= 2) ? (o_dv_n[1] - o_dv_n[0]) : 0, s.exp_gap);
    check_int({tag, "_busy_low_at"}, o_busy_low, s.exp_busy_low);
  endtask

  scen_t tbl[7];

  initial begin
    tbl[0] = '{8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 8,  0, 6,  80,  0,  81};
    tbl[1] = '{8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0,  0, 6,  -1,  0,  8};
    tbl[2] = '{16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 8,  1, 10, 176, 0,  177};
    tbl[3] = '{8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 8,  0, 6,  80,  0,  81};
    tbl[4] = '{8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 16, 0, 6,  80,  80, 161};
    tbl[5] = '{32, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 8,  1, 18, 352, 0,  353};
    tbl[6] = '{16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 8,  0, 10, 160, 0,  161};

    // Reset state.
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PRESCALE = PW'(8);
    STRT_GLITCH = 1'b0; PAR_ERR = 1'b0; STP_ERR = 1'b0;
    #2;
    check_int("reset_outputs", int'(dut_vec()), 0);
    repeat (3) cycle();
    RST = 1'b1;
    repeat (5) cycle();

    // Directed frame scenarios.
    for (int i = 0; i < 7; i++) run_scen(tbl[i], i);

    // Reset asserted mid-frame in DATA at bit 4.
    PRESCALE = PW'(8); PAR_EN = 1'b0; STRT_GLITCH = 1'b0;
    PAR_ERR = 1'b0; STP_ERR = 1'b0; RX_IN = 1'b1;
    repeat (2) cycle();
    RX_IN = 1'b0;
    cycle();
    for (int n = 0; n < 34; n++) begin
      RX_IN = frame_rx(n, 8);
      cycle();
    end
    check_int("bit_cnt_before_reset", int'(BIT_CNT), 4);
    RST = 1'b0;
    m_mode = 0;
    #1;
    check_int("outputs_in_mid_frame_reset", int'(dut_vec()), 0);
    RX_IN = 1'b1;
    repeat (3) cycle();
    RST = 1'b1;
    repeat (3) cycle();
    run_scen(tbl[0], 7);

    // Random stimulus against the reference model.
    for (int i = 0; i < 8000; i++) begin
      RST = ($urandom_range(999) == 0) ? 1'b0 : 1'b1;
      if (!RST) m_mode = 0;
      RX_IN = ($urandom_range(3) == 0) ? 1'b0 : 1'b1;
      PAR_EN = 1'($urandom_range(1));
      case ($urandom_range(2))
        0:       PRESCALE = PW'(8);
        1:       PRESCALE = PW'(16);
        default: PRESCALE = PW'(32);
      endcase
      STRT_GLITCH = ($urandom_range(7) == 0);
      PAR_ERR = 1'($urandom_range(1));
      STP_ERR = ($urandom_range(3) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
